transition_word_gen: RTL and testbench
======================================

TRANSITION_WORD_GEN -- requirements
Module: transition_word_gen

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port Clear, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port Load, input, 1 bit: start or restart an enumeration with Target.
REQ-004 SHALL have port Target, input, 4 bits: required bit-transition count.
REQ-005 SHALL have port Next, input, 1 bit: consumer acknowledges the presented word.
REQ-006 SHALL have port Data, output, 10 bits: presented word.
REQ-007 SHALL have port Valid, output, 1 bit: Data holds a matching word.
REQ-008 SHALL have port Busy, output, 1 bit: high in SEARCH and HOLD.
REQ-009 SHALL have port Done, output, 1 bit: enumeration exhausted.
REQ-010 SHALL have port Found, output, 10 bits: matching words presented since last Load.

Function
REQ-011 SHALL define transitions(w) as popcount(w[9:1] XOR w[8:0]), range 0..9.
REQ-012 SHALL implement FSM states IDLE, SEARCH, HOLD, DONE; all outputs registered.
REQ-013 IDLE: Load=1 -> latch Target, candidate=0, Found=0, go SEARCH; otherwise stay.
REQ-014 Load=1 with Target>9 SHALL go directly to DONE with Found=0 and Valid=0.
REQ-015 SEARCH: evaluate one candidate per cycle; on match -> Data=candidate, Valid=1, Found+1, go HOLD.
REQ-016 SEARCH: on mismatch with candidate<1023 -> candidate+1, stay in SEARCH.
REQ-017 SEARCH: on mismatch with candidate=1023 -> go DONE (no wrap).
REQ-018 HOLD: Data and Valid SHALL remain stable until Next=1 is sampled.
REQ-019 HOLD with Next=1: Valid=0 next cycle; candidate<1023 -> candidate+1, go SEARCH; candidate=1023 -> go DONE.
REQ-020 DONE: Done=1, Valid=0, Busy=0, Data and Found retain last values; Load=1 restarts per REQ-013/014.
REQ-021 Load=1 in any state SHALL restart per REQ-013/014 and SHALL take priority over Next.
REQ-022 Next=1 outside HOLD SHALL be ignored.
REQ-023 Latency: with Load sampled at edge n, candidate 0 is evaluated at edge n+1; if it matches, Valid=1 after edge n+1.
REQ-024 Words SHALL be presented in strictly ascending order; count per Target k SHALL equal 2*C(9,k).
REQ-025 Found SHALL NOT wrap; its maximum value is 252 (k=4 or 5).

Reset
REQ-026 Clear=0 SHALL immediately force IDLE, Data=0, Valid=0, Busy=0, Done=0, Found=0, candidate=0, latched Target=0.
REQ-027 Clear asserted mid-SEARCH or mid-HOLD SHALL abandon the enumeration; after release the block stays in IDLE until Load.
REQ-028 Clear release SHALL be synchronous-safe: first state change occurs no earlier than the first edge after release.

Verification
REQ-029 Reset: Clear=0 mid-HOLD -> all outputs 0 at once; after release, with no Load, outputs stay 0.
REQ-030 Target=0, Next pulsed after each Valid -> Data 0x000 then 0x3FF, then Done=1, Found=2.
REQ-031 Target=9 -> Data 0x155 then 0x2AA, then Done=1, Found=2.
REQ-032 Target=1 -> 18 ascending words, first 0x001, last 0x3FE, each with exactly one transition, then Done=1, Found=18.
REQ-033 Target=10 -> Done=1 one cycle after Load, Valid never asserted, Found=0.
REQ-034 Load with Target=4 asserted together with Next during HOLD of a Target=2 run -> restart, Found=0, first word 0x00A.

Source files
------------

// File: rtl/transition_word_gen.sv
// Enumerates, in ascending order, every 10-bit word whose adjacent-bit
// transition count equals the loaded Target, handing each one over with a Valid/Next handshake.
module transition_word_gen (
    input  logic       CLK,
    input  logic       Clear,
    input  logic       Load,
    input  logic [3:0] Target,
    input  logic       Next,
    output logic [9:0] Data,
    output logic       Valid,
    output logic       Busy,
    output logic       Done,
    output logic [9:0] Found
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_TRANSITIONS = 4'd9;

    state_t     state_q;
    logic [9:0] cand_q;
    logic [3:0] target_q;
    logic [9:0] data_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;
    logic [9:0] found_q;

    logic [9:0] cand_d;
    logic [3:0] cand_trans;
    logic       cand_match;
    logic       cand_last;

    function automatic logic [3:0] transitions(input logic [9:0] w);
        logic [8:0] diff;
        logic [3:0] cnt;
        diff = w[9:1] ^ w[8:0];
        cnt  = 4'd0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + {3'd0, diff[i]};
        end
        return cnt;
    endfunction

    assign cand_trans = transitions(cand_q);
    assign cand_match = (cand_trans == target_q);
    assign cand_last  = &cand_q;
    assign cand_d     = cand_q + 10'd1;

    // Load outranks every state-specific action, including a Next in HOLD.
    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            state_q  <= IDLE;
            cand_q   <= 10'd0;
            target_q <= 4'd0;
            data_q   <= 10'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 10'd0;
        end else if (Load) begin
            target_q <= Target;
            cand_q   <= 10'd0;
            found_q  <= 10'd0;
            valid_q  <= 1'b0;
            if (Target > MAX_TRANSITIONS) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                state_q <= SEARCH;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                SEARCH: begin
                    if (cand_match) begin
                        data_q  <= cand_q;
                        valid_q <= 1'b1;
                        found_q <= found_q + 10'd1;
                        state_q <= HOLD;
                    end else if (cand_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cand_q  <= cand_d;
                    end
                end
                HOLD: begin
                    if (Next) begin
                        valid_q <= 1'b0;
                        if (cand_last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cand_q  <= cand_d;
                            state_q <= SEARCH;
                        end
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Data  = data_q;
    assign Valid = valid_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Found = found_q;

endmodule

// File: tb/tb_transition_word_gen.sv
// Directed bench for transition_word_gen: table of full enumerations plus
// hand-written reset, out-of-range target and Load-over-Next sequences.
module tb_transition_word_gen;

    logic       CLK = 1'b0;
    logic       Clear;
    logic       Load;
    logic [3:0] Target;
    logic       Next;
    logic [9:0] Data;
    logic       Valid;
    logic       Busy;
    logic       Done;
    logic [9:0] Found;

    int errors = 0;
    int checks = 0;

    transition_word_gen dut (
        .CLK    (CLK),
        .Clear  (Clear),
        .Load   (Load),
        .Target (Target),
        .Next   (Next),
        .Data   (Data),
        .Valid  (Valid),
        .Busy   (Busy),
        .Done   (Done),
        .Found  (Found)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] target;
        int         count;
        logic [9:0] first;
        logic [9:0] last;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int trans_count(input logic [9:0] w);
        int c = 0;
        for (int i = 0; i < 9; i++) begin
            if (w[i] != w[i+1]) c++;
        end
        return c;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_data"},  {22'd0, Data},  32'd0);
        check({name, "_valid"}, {31'd0, Valid}, 32'd0);
        check({name, "_busy"},  {31'd0, Busy},  32'd0);
        check({name, "_done"},  {31'd0, Done},  32'd0);
        check({name, "_found"}, {22'd0, Found}, 32'd0);
    endtask

    // Returns at the falling edge right after the edge that sampled Load.
    task automatic do_load(input logic [3:0] t);
        @(negedge CLK);
        Target = t;
        Load   = 1'b1;
        @(negedge CLK);
        Load   = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int cyc = 0;
        while (!Valid && cyc < bound) begin
            @(negedge CLK);
            cyc++;
        end
        check({name, "_valid_seen"}, {31'd0, Valid}, 32'd1);
    endtask

    task automatic run_enum(input int idx);
        int         n = 0;
        int         first_iter = -1;
        logic [9:0] first = 10'd0;
        logic [9:0] prev = 10'd0;
        logic       finished = 1'b0;
        logic       word_ok;
        do_load(vecs[idx].target);
        check("busy_after_load",  {31'd0, Busy},  32'd1);
        check("valid_after_load", {31'd0, Valid}, 32'd0);
        for (int iter = 0; iter < 4000 && !finished; iter++) begin
            if (Valid) begin
                n++;
                word_ok = (trans_count(Data) == int'(vecs[idx].target)) &&
                          (n == 1 || Data > prev) && (int'(Found) == n);
                if (!word_ok)
                    $display("FAIL word target=%0d n=%0d actual=0x%03h found=%0d", vecs[idx].target, n, Data, Found);
                checks++;
                if (!word_ok) errors++;
                if (n == 1) begin
                    first      = Data;
                    first_iter = iter;
                end
                prev = Data;
                Next = 1'b1;
                @(negedge CLK);
                Next = 1'b0;
            end else if (Done) begin
                finished = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
        $display("run target=%0d words=%0d first=0x%03h last=0x%03h found=%0d done=%0b",
                 vecs[idx].target, n, first, prev, Found, Done);
        check("done_at_end",  {31'd0, Done},  32'd1);
        check("busy_at_end",  {31'd0, Busy},  32'd0);
        check("valid_at_end", {31'd0, Valid}, 32'd0);
        check("word_count",   n, vecs[idx].count);
        check("found_at_end", {22'd0, Found}, vecs[idx].count);
        check("first_word",   {22'd0, first}, {22'd0, vecs[idx].first});
        check("last_word",    {22'd0, prev},  {22'd0, vecs[idx].last});
        check("data_retained", {22'd0, Data}, {22'd0, vecs[idx].last});
        if (vecs[idx].first == 10'd0)
            check("first_latency", first_iter, 1);
    endtask

    initial begin
        vecs[0] = '{target: 4'd0, count: 2,   first: 10'h000, last: 10'h3FF};
        vecs[1] = '{target: 4'd9, count: 2,   first: 10'h155, last: 10'h2AA};
        vecs[2] = '{target: 4'd1, count: 18,  first: 10'h001, last: 10'h3FE};
        vecs[3] = '{target: 4'd2, count: 72,  first: 10'h002, last: 10'h3FD};
        vecs[4] = '{target: 4'd4, count: 252, first: 10'h00A, last: 10'h3F5};

        Load   = 1'b0;
        Next   = 1'b0;
        Target = 4'd0;
        Clear  = 1'b1;
        #1 Clear = 1'b0;
        #1 check_all_zero("por");
        @(negedge CLK);
        Clear = 1'b1;
        repeat (3) @(negedge CLK);
        check_all_zero("idle_no_load");

        for (int i = 0; i < 5; i++) begin
            run_enum(i);
        end

        // Next in DONE must not disturb anything.
        Next = 1'b1;
        @(negedge CLK);
        Next = 1'b0;
        @(negedge CLK);
        check("done_next_ignored", {31'd0, Done}, 32'd1);
        check("done_next_found", {22'd0, Found}, 32'd252);
        $display("next_in_done done=%0b found=%0d", Done, Found);

        do_load(4'd10);
        check("t10_done",  {31'd0, Done},  32'd1);
        check("t10_busy",  {31'd0, Busy},  32'd0);
        check("t10_valid", {31'd0, Valid}, 32'd0);
        check("t10_found", {22'd0, Found}, 32'd0);
        repeat (4) @(negedge CLK);
        check("t10_valid_later", {31'd0, Valid}, 32'd0);
        $display("load target=10 done=%0b valid=%0b found=%0d", Done, Valid, Found);

        do_load(4'd2);
        wait_valid("t2", 20);
        check("t2_first", {22'd0, Data}, 32'h002);
        Target = 4'd4;
        Load   = 1'b1;
        Next   = 1'b1;
        @(negedge CLK);
        Load = 1'b0;
        Next = 1'b0;
        check("restart_found", {22'd0, Found}, 32'd0);
        check("restart_valid", {31'd0, Valid}, 32'd0);
        check("restart_busy",  {31'd0, Busy},  32'd1);
        wait_valid("t4_restart", 40);
        check("restart_first", {22'd0, Data},  32'h00A);
        check("restart_count", {22'd0, Found}, 32'd1);
        $display("load-over-next data=0x%03h found=%0d", Data, Found);

        do_load(4'd9);
        wait_valid("t9_hold", 600);
        check("hold_data", {22'd0, Data}, 32'h155);
        repeat (3) @(negedge CLK);
        check("hold_stable", {22'd0, Data}, 32'h155);
        check("hold_valid_stable", {31'd0, Valid}, 32'd1);
        #2 Clear = 1'b0;
        #1 check_all_zero("clear_in_hold");
        @(negedge CLK);
        Clear = 1'b1;
        repeat (5) @(negedge CLK);
        check_all_zero("after_clear");
        $display("clear mid-hold valid=%0b busy=%0b found=%0d", Valid, Busy, Found);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
